// File: rtl/cbd_tc_ctrl.sv
// rtl/cbd_tc_ctrl.sv - run controller for an 8-bit cascaded down-counter chain (SD/EN/CAI/CAO)
// Optional CAI prescaler is enabled by defining CBD_TC_PRESCALE_EN.
module cbd_tc_ctrl #(
  parameter int EVT_W    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             cao,
  input  logic             irq_ack,
  output logic             sd,
  output logic             en,
  output logic             cai,
  output logic             irq,
  output logic             ovr,
  output logic [EVT_W-1:0] evt_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRESET = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic             sd_q, sd_d;
  logic             en_q, en_d;
  logic             cai_q, cai_d;
  logic             irq_q, irq_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic             evt;
  logic             start_acc;

`ifdef CBD_TC_PRESCALE_EN
  localparam int             PW      = $clog2(PRESCALE);
  localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);
  logic [PW-1:0]             pre_q, pre_d;
`endif

  always_comb begin
    evt       = cao && (state_q == S_RUN);
    start_acc = start && !stop && (state_q != S_PRESET);

    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_acc) state_d = S_PRESET;
      S_PRESET: state_d = S_RUN;
      S_RUN: begin
        if (stop)                 state_d = S_IDLE;
        else if (start_acc)       state_d = S_PRESET;
        else if (cao && !mode_q)  state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase

    mode_d = start_acc ? mode : mode_q;

    // An event in the same cycle as the acknowledge keeps IRQ set.
    if (evt)          irq_d = 1'b1;
    else if (irq_ack) irq_d = 1'b0;
    else              irq_d = irq_q;

    if (start_acc)                    ovr_d = 1'b0;
    else if (evt && irq_q && !irq_ack) ovr_d = 1'b1;
    else if (irq_ack)                 ovr_d = 1'b0;
    else                              ovr_d = ovr_q;

    // Restart clear wins over an event counted in the same cycle.
    if (start_acc)                       evt_cnt_d = '0;
    else if (evt && (evt_cnt_q != '1))   evt_cnt_d = evt_cnt_q + EVT_W'(1);
    else                                 evt_cnt_d = evt_cnt_q;

    sd_d   = (state_d == S_PRESET);
    en_d   = (state_d == S_RUN);
    busy_d = (state_d != S_IDLE);

`ifdef CBD_TC_PRESCALE_EN
    pre_d = '0;
    if ((state_d == S_RUN) && (state_q == S_RUN))
      pre_d = (pre_q == PS_LAST) ? '0 : pre_q + PW'(1);
    cai_d = (state_d == S_RUN) && (pre_d == '0);
`else
    cai_d = (state_d == S_RUN) && (PRESCALE > 0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      sd_q      <= 1'b0;
      en_q      <= 1'b0;
      cai_q     <= 1'b0;
      irq_q     <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
      evt_cnt_q <= '0;
`ifdef CBD_TC_PRESCALE_EN
      pre_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      sd_q      <= sd_d;
      en_q      <= en_d;
      cai_q     <= cai_d;
      irq_q     <= irq_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
      evt_cnt_q <= evt_cnt_d;
`ifdef CBD_TC_PRESCALE_EN
      pre_q     <= pre_d;
`endif
    end
  end

  assign sd      = sd_q;
  assign en      = en_q;
  assign cai     = cai_q;
  assign irq     = irq_q;
  assign ovr     = ovr_q;
  assign busy    = busy_q;
  assign evt_cnt = evt_cnt_q;

endmodule

// File: tb/tb_cbd_tc_ctrl.sv
// tb/tb_cbd_tc_ctrl.sv - randomized and directed bench for cbd_tc_ctrl against a behavioural model
module tb_cbd_tc_ctrl;

  localparam int EVT_W   = 2;
  localparam int PS      = 4;
`ifdef CBD_TC_PRESCALE_EN
  localparam int P_EFF   = PS;
`else
  localparam int P_EFF   = 1;
`endif
  localparam int EVT_MAX = (1 << EVT_W) - 1;
  localparam int FIRST   = 255 * P_EFF + 1;
  localparam int PERIOD  = 256 * P_EFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, mode = 1'b0, cao = 1'b0, irq_ack = 1'b0;
  logic sd, en, cai, irq, ovr, busy;
  logic [EVT_W-1:0] evt_cnt;
  logic [7:0] chain = 8'hFF;

  int errors = 0;
  int checks = 0;

  int m_phase, m_mode, m_irq, m_ovr, m_cnt, m_run_idx;

  always #5 clk = ~clk;

  cbd_tc_ctrl #(.EVT_W(EVT_W), .PRESCALE(PS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .cao(cao), .irq_ack(irq_ack), .sd(sd), .en(en), .cai(cai), .irq(irq),
    .ovr(ovr), .evt_cnt(evt_cnt), .busy(busy)
  );

  // Counter chain: preset to FF, decrement on EN&CAI, carry out when at zero with carry in.
  always @(posedge clk) begin
    if (sd)             chain <= 8'hFF;
    else if (en && cai) chain <= chain - 8'd1;
  end

  function automatic bit chain_cao();
    return en && cai && (chain == 8'd0);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_mode = 0; m_irq = 0; m_ovr = 0; m_cnt = 0; m_run_idx = 0;
  endtask

  // phase: 0 idle, 1 preset, 2 run
  task automatic model_step(input bit s, input bit p, input bit md, input bit c, input bit a);
    bit evt, acc;
    int nxt;
    evt = (m_phase == 2) && c;
    acc = s && !p && (m_phase != 1);
    nxt = m_phase;
    if (m_phase == 0)      nxt = acc ? 1 : 0;
    else if (m_phase == 1) nxt = 2;
    else if (p)            nxt = 0;
    else if (acc)          nxt = 1;
    else if (c && m_mode == 0) nxt = 0;
    if (acc) m_ovr = 0;
    else if (evt && m_irq == 1 && !a) m_ovr = 1;
    else if (a) m_ovr = 0;
    if (evt) m_irq = 1;
    else if (a) m_irq = 0;
    m_cnt = acc ? 0 : m_cnt + int'(evt);
    if (acc) m_mode = md;
    m_run_idx = (nxt == 2 && m_phase == 2) ? m_run_idx + 1 : 0;
    m_phase = nxt;
  endtask

  task automatic check_all();
    chk("sd", sd, 8'(m_phase == 1));
    chk("en", en, 8'(m_phase == 2));
    chk("busy", busy, 8'(m_phase != 0));
    chk("cai", cai, 8'((m_phase == 2) && (m_run_idx % P_EFF == 0)));
    chk("irq", irq, 8'(m_irq));
    chk("ovr", ovr, 8'(m_ovr));
    chk("evt_cnt", evt_cnt, 8'((m_cnt > EVT_MAX) ? EVT_MAX : m_cnt));
  endtask

  task automatic tick(input bit s, input bit p, input bit md, input bit a, input bit inj);
    bit c;
    c = chain_cao() || inj;
    start = s; stop = p; mode = md; irq_ack = a; cao = c;
    @(posedge clk);
    @(negedge clk);
    start = 0; stop = 0; irq_ack = 0; cao = 0;
    model_step(s, p, md, c, a);
    check_all();
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_outputs", {sd, en, cai, irq, ovr, busy, evt_cnt}, 8'd0);
    rst_n = 1'b1;
    check_all();

    // One-shot run
    tick(1, 0, 0, 0, 0);
    chk("oneshot_sd", sd, 8'd1);
    n = 0;
    while (!irq && n < 3000) begin
      tick(0, 0, 0, 0, 0);
      if (en) n++;
    end
    chk("oneshot_run_cycles", 8'(n == FIRST), 8'd1);
    chk("oneshot_evt_cnt", evt_cnt, 8'd1);
    chk("oneshot_en_off", en, 8'd0);
    chk("oneshot_busy_off", busy, 8'd0);
    tick(0, 0, 0, 1, 0);
    chk("oneshot_ack", irq, 8'd0);
    tick(0, 0, 0, 0, 1);
    chk("idle_cao_ignored", {irq, evt_cnt}, 8'd1);

    // Periodic, no ack over three periods, then saturation
    tick(1, 0, 1, 0, 0);
    n = 1;
    while (evt_cnt != 2'd3 && n < 6000) begin
      tick(0, 0, 0, 0, 0);
      n++;
    end
    chk("periodic_third_evt_tick", 8'(n == FIRST + 2 * PERIOD + 2), 8'd1);
    chk("periodic_irq_ovr", {irq, ovr}, 8'd3);
    tick(0, 0, 0, 1, 0);
    chk("periodic_ack_clears", {irq, ovr}, 8'd0);
    for (int i = 0; i < 2 * PERIOD; i++) tick(0, 0, 0, 0, 0);
    chk("saturated_evt_cnt", evt_cnt, 8'd3);
    chk("model_raw_count", 8'(m_cnt), 8'd5);
    tick(0, 1, 0, 0, 0);
    chk("stop_idle", {en, busy}, 8'd0);

    // Acknowledge coincident with the second terminal count
    tick(1, 0, 1, 0, 0);
    n = 0;
    while (m_cnt < 1 && n < 3000) begin tick(0, 0, 0, 0, 0); n++; end
    n = 0;
    while (!chain_cao() && n < 3000) begin tick(0, 0, 0, 0, 0); n++; end
    tick(0, 0, 0, 1, 0);
    chk("ack_evt_irq", irq, 8'd1);
    chk("ack_evt_ovr", ovr, 8'd0);
    chk("ack_evt_cnt", evt_cnt, 8'd2);

    // Simultaneous requests
    tick(1, 1, 0, 0, 0);
    chk("start_stop_idle", {sd, en, busy}, 8'd0);
    tick(1, 0, 1, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk("start_in_preset_ignored", {sd, en}, 8'd1);
    repeat (3) tick(0, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0);
    chk("restart_sd", sd, 8'd1);
    chk("restart_evt_cnt", evt_cnt, 8'd0);
    repeat (3) tick(0, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 1);
    chk("cao_start_cnt", {sd, irq, evt_cnt}, 8'b0000_1100);
    repeat (3) tick(0, 0, 0, 0, 0);
    tick(0, 1, 1, 0, 1);
    chk("cao_stop", {busy, evt_cnt}, 8'd1);

    // Asynchronous reset mid-run
    tick(1, 0, 1, 0, 0);
    repeat (5) tick(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {sd, en, cai, irq, ovr, busy, evt_cnt}, 8'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    tick(0, 0, 0, 0, 0);
    chk("post_reset_busy", busy, 8'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(59) == 0, $urandom_range(399) == 0, 1'($urandom_range(1)),
           $urandom_range(7) == 0, $urandom_range(39) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
